// File: rtl/sd_dat_transfer_sequencer.sv
// DAT-line block transfer sequencer: arbitrates DMA/PIO requesters onto the phys.
// Optional build macro SD_DAT_RETRY_EN re-issues a timed-out transfer up to MAX_RETRY times.
module sd_dat_transfer_sequencer #(
    parameter logic [15:0] TIMEOUT_DEFAULT = 16'hFFFF
`ifdef SD_DAT_RETRY_EN
    ,
    parameter int MAX_RETRY = 2
`endif
) (
    input  logic        sd_clock,
    input  logic        reset,
    input  logic [1:0]  req_i,
    input  logic [1:0]  wr_i,
    input  logic [1:0]  mult_i,
    input  logic [3:0]  blocks0_i,
    input  logic [3:0]  blocks1_i,
    output logic [1:0]  grant_o,
    output logic [1:0]  done_o,
    output logic        err_o,
    output logic        strobe_o,
    output logic        ack_o,
    output logic        idle_o,
    output logic        wr_o,
    output logic        mult_o,
    output logic [3:0]  blocks_o,
    output logic [15:0] timeout_reg_o,
    input  logic        phys_ready_i,
    input  logic        phys_cmpl_i,
    input  logic        phys_ack_i,
    input  logic        phys_tmo_i
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_ARB     = 4'd1,
        S_ISSUE   = 4'd2,
        S_BUSY    = 4'd3,
        S_ACK     = 4'd4,
        S_ABORT   = 4'd5,
        S_RETRY   = 4'd6,
        S_RELEASE = 4'd7
    } state_t;

    state_t state, state_d;

    logic [1:0] grant_d, done_d;
    logic       err_d, strobe_d, ack_d, idle_d;
    logic       wr_d, mult_d;
    logic [3:0] blocks_d;
    logic       last, last_d;
    logic       win;
    logic       retry_ok;

    assign timeout_reg_o = TIMEOUT_DEFAULT;

    // Tie goes to the requester that did not win last time.
    assign win = (req_i == 2'b10) || (req_i == 2'b11 && !last);

`ifdef SD_DAT_RETRY_EN
    localparam logic [1:0] MAX_R = 2'(MAX_RETRY);
    logic [1:0] retry_cnt, retry_cnt_d;
    assign retry_ok = (retry_cnt < MAX_R);
`else
    assign retry_ok = 1'b0;
`endif

    always_ff @(posedge sd_clock) begin
        if (reset) begin
            state    <= S_IDLE;
            grant_o  <= 2'b00;
            done_o   <= 2'b00;
            err_o    <= 1'b0;
            strobe_o <= 1'b0;
            ack_o    <= 1'b0;
            idle_o   <= 1'b1;
            wr_o     <= 1'b0;
            mult_o   <= 1'b0;
            blocks_o <= 4'd0;
            last     <= 1'b1;
        end else begin
            state    <= state_d;
            grant_o  <= grant_d;
            done_o   <= done_d;
            err_o    <= err_d;
            strobe_o <= strobe_d;
            ack_o    <= ack_d;
            idle_o   <= idle_d;
            wr_o     <= wr_d;
            mult_o   <= mult_d;
            blocks_o <= blocks_d;
            last     <= last_d;
        end
    end

`ifdef SD_DAT_RETRY_EN
    always_ff @(posedge sd_clock) begin
        if (reset) retry_cnt <= 2'd0;
        else       retry_cnt <= retry_cnt_d;
    end
`endif

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:    if (|req_i) state_d = S_ARB;
            S_ARB:     state_d = (|req_i) ? S_ISSUE : S_IDLE;
            S_ISSUE:   if (phys_ready_i) state_d = S_BUSY;
            S_BUSY: begin
                if (phys_cmpl_i)     state_d = S_ACK;
                else if (phys_tmo_i) state_d = S_ABORT;
            end
            S_ACK:     if (phys_ack_i) state_d = S_RELEASE;
            S_ABORT:   state_d = S_RETRY;
            S_RETRY:   state_d = retry_ok ? S_ISSUE : S_RELEASE;
            S_RELEASE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        grant_d  = grant_o;
        done_d   = 2'b00;
        err_d    = 1'b0;
        strobe_d = 1'b0;
        ack_d    = ack_o;
        idle_d   = 1'b0;
        wr_d     = wr_o;
        mult_d   = mult_o;
        blocks_d = blocks_o;
        last_d   = last;
`ifdef SD_DAT_RETRY_EN
        retry_cnt_d = retry_cnt;
`endif
        case (state)
            S_ARB: begin
                if (|req_i) begin
                    grant_d  = win ? 2'b10 : 2'b01;
                    wr_d     = wr_i[win];
                    mult_d   = mult_i[win];
                    blocks_d = win ? blocks1_i : blocks0_i;
                    last_d   = win;
                end
            end
            S_ISSUE:   strobe_d = phys_ready_i;
            S_BUSY: begin
                if (phys_cmpl_i)     ack_d  = 1'b1;
                else if (phys_tmo_i) idle_d = 1'b1;
            end
            S_ACK: begin
                if (phys_ack_i) begin
                    ack_d  = 1'b0;
                    done_d = grant_o;
                end
            end
            S_RETRY: begin
                if (!retry_ok) begin
                    done_d = grant_o;
                    err_d  = 1'b1;
                end
`ifdef SD_DAT_RETRY_EN
                else if (retry_cnt != 2'd3) begin
                    retry_cnt_d = retry_cnt + 2'd1;
                end
`endif
            end
            S_RELEASE: begin
                grant_d = 2'b00;
`ifdef SD_DAT_RETRY_EN
                retry_cnt_d = 2'd0;
`endif
            end
            S_IDLE, S_ABORT: ;
            default: begin
                grant_d = 2'b00;
                ack_d   = 1'b0;
                idle_d  = 1'b1;
            end
        endcase
    end

endmodule
